// File: rtl/mips_defs.sv
// Shared MIPS32 decode constants for the pipeline stages.
// Opcode/funct/rs field values and the write-back source selector.
package mips_defs;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_COP0    = 6'h10;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;

   localparam logic [5:0] FUNCT_JALR = 6'h09;
   localparam logic [4:0] RS_MF      = 5'h00;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_LINK,
      WB_CP0,
      WB_LOAD
   } wb_sel_t;

endpackage

// File: rtl/load_ext.sv
// Load-data extraction: picks the addressed byte/half from the aligned memory
// word and sign- or zero-extends it; full words pass through unchanged.
module load_ext
   import mips_defs::*;
(
   input  logic [31:0] RDW,
   input  logic [1:0]  addr,
   input  logic [5:0]  op,
   output logic [31:0] load_val
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
      byte_v = RDW[7:0];
      case (addr)
         2'd1:    byte_v = RDW[15:8];
         2'd2:    byte_v = RDW[23:16];
         2'd3:    byte_v = RDW[31:24];
         default: byte_v = RDW[7:0];
      endcase

      // addr[0] is ignored for halves; misalignment traps before this stage
      half_v = addr[1] ? RDW[31:16] : RDW[15:0];

      load_val = RDW;
      case (op)
         OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  load_val = {24'd0, byte_v};
         OP_LH:   load_val = {{16{half_v[15]}}, half_v};
         OP_LHU:  load_val = {16'd0, half_v};
         default: load_val = RDW;
      endcase
   end

endmodule

// File: rtl/wb_grf.sv
// MIPS32 write-back stage and general register file: write-back select,
// 31-entry GPR array with W->D bypassed read ports, and a retired counter.
module wb_grf
   import mips_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALURstW,
   input  logic [31:0] RDW,
   input  logic [31:0] PCplus8W,
   input  logic [4:0]  A3W,
   input  logic [31:0] InstrW,
   input  logic [31:0] CP0RDW,
   input  logic [4:0]  A1D,
   input  logic [4:0]  A2D,
   output logic [31:0] RD1D,
   output logic [31:0] RD2D,
   output logic [31:0] WDW,
   output logic [31:0] retired
);

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [5:0]  funct;
   wb_sel_t     wb_sel;
   logic [31:0] load_val;
   logic [31:0] gpr [1:31];
   logic [31:0] retired_q;

   assign op    = InstrW[31:26];
   assign rs    = InstrW[25:21];
   assign funct = InstrW[5:0];

   load_ext u_load_ext (
      .RDW      (RDW),
      .addr     (ALURstW[1:0]),
      .op       (op),
      .load_val (load_val)
   );

   always_comb begin
      wb_sel = WB_ALU;
      if (op == OP_JAL || (op == OP_SPECIAL && funct == FUNCT_JALR))
         wb_sel = WB_LINK;
      else if (op == OP_COP0 && rs == RS_MF)
         wb_sel = WB_CP0;
      else if (op == OP_LW || op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU)
         wb_sel = WB_LOAD;
   end

   always_comb begin
      WDW = ALURstW;
      case (wb_sel)
         WB_LINK: WDW = PCplus8W;
         WB_CP0:  WDW = CP0RDW;
         WB_LOAD: WDW = load_val;
         default: WDW = ALURstW;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: the array is reset because gpr must read 0 afterwards; this keeps it in flops, not a RAM macro.
      if (reset) begin
         for (int i = 1; i < 32; i++)
            gpr[i] <= '0;
      end else if (A3W != 5'd0) begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         gpr[A3W] <= WDW;
      end
   end

   // Same-cycle bypass hides the W->D hazard; r0 is hardwired ahead of it
   always_comb begin
      RD1D = '0;
      if (A1D == 5'd0)      RD1D = '0;
      else if (A1D == A3W)  RD1D = WDW;
      else                  RD1D = gpr[A1D];
   end

   always_comb begin
      RD2D = '0;
      if (A2D == 5'd0)      RD2D = '0;
      else if (A2D == A3W)  RD2D = WDW;
      else                  RD2D = gpr[A2D];
   end

   assign retired = retired_q;

   always_ff @(posedge clk) begin
      if (reset)
         retired_q <= '0;
      else if (InstrW != 32'd0)
         retired_q <= retired + 32'd1;
   end

endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back stage plus general register file for the 5-stage MIPS32 pipeline. Consumes the M/W pipeline register outputs, performs load-data extraction and sign/zero extension, selects the write-back value, and commits it to a 32×32 GPR array. Provides two bypassed read ports to the decode stage and a retired-instruction counter for debug and verification.

## Interface
- No parameters. Widths are fixed by the MIPS32 ISA.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; clock clk
- ALURstW  in  32  ALU result and load/store byte address from W stage
- RDW  in  32  raw aligned word read from data memory
- PCplus8W  in  32  link address for jal/jalr
- A3W  in  5  destination register; 0 means no write
- InstrW  in  32  instruction in W stage; 0 is a bubble
- CP0RDW  in  32  CP0 read data for mfc0
- A1D  in  5  decode read address 1
- A2D  in  5  decode read address 2
- RD1D  out  32  read data 1, bypassed
- RD2D  out  32  read data 2, bypassed
- WDW  out  32  selected write-back value, to the forwarding network
- retired  out  32  count of non-bubble instructions retired

## Operation
- Decode uses InstrW[31:26] (op), [25:21] (rs), and [5:0] (funct).
- Write-back select, in priority order:
  - op 0x03 (jal), or op 0x00 with funct 0x09 (jalr) → PCplus8W.
  - op 0x10 with rs 0x00 (mfc0) → CP0RDW.
  - op 0x23 (lw) → RDW.
  - op 0x20/0x24 (lb/lbu) → byte RDW[8·ALURstW[1:0]+7 : 8·ALURstW[1:0]], sign- or zero-extended to 32 bits.
  - op 0x21/0x25 (lh/lhu) → half RDW[16·ALURstW[1]+15 : 16·ALURstW[1]], sign- or zero-extended. ALURstW[0] is ignored; alignment exceptions are raised upstream.
  - All other encodings → ALURstW.
- Write: on a posedge with reset low and A3W≠0, gpr[A3W] ← WDW. gpr[0] is never written and always reads 0.
- Read ports: RDnD = 0 if AnD=0; else WDW if AnD=A3W; else gpr[AnD]. The bypass removes the W→D hazard within the same cycle.
- retired increments by 1 on each posedge with reset low and InstrW≠0. It wraps from 0xFFFFFFFF to 0.

## Timing
- Read ports and WDW are combinational from their inputs; no added latency.
- Register write completes at the posedge. A read of the same register in the following cycle returns the new value directly from the array.
- Reset values:
  - gpr[1..31] = 0 after the reset edge.
  - retired = 0.
  - RD1D/RD2D are driven to 0 through the array, except where the bypass applies with A3W≠0.
- Reset asserted mid-stream:
  - The reset edge suppresses any pending write.
  - It clears all registers and the counter, even if A3W≠0 and InstrW≠0 at that edge.
- A1D=A2D=A3W: both ports return WDW.
- A bubble with A3W≠0 is not expected; if it occurs, the write still happens and retired does not count it.

## Structure
- Shared package `mips_defs`:
  - opcode constants: OP_SPECIAL, OP_JAL, OP_COP0, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU.
  - FUNCT_JALR and RS_MF.
- One sub-module, `load_ext`: purely combinational. Inputs are RDW, ALURstW[1:0], and op; output is the extended load value.
- The top level holds the select mux, the 31-entry array, bypass logic, and the counter.

## Test plan
- Reset, then read all 32 addresses → all 0. retired = 0.
- InstrW = lb op, ALURstW = 0x1003, RDW = 0x80FF1234, A3W = 5:
  - WDW = 0xFFFFFF80.
  - Next cycle A1D = 5 → RD1D = 0xFFFFFF80.
  - Repeat with lbu → 0x00000080.
- lh, ALURstW = 0x2002, RDW = 0x8001ABCD → WDW = 0xFFFF8001. lhu → 0x00008001.
- Bypass:
  - jal with PCplus8W = 0x00003008, A3W = 31, and A1D = A2D = 31 in the same cycle → RD1D = RD2D = 0x00003008 before the edge.
  - A3W = 0 with ALURstW = 0xDEADBEEF → gpr[0] reads 0.
- Counter: 10 non-bubble instructions mixed with 3 bubbles → retired = 10. Force the counter to 0xFFFFFFFF, retire 1 → 0.
- mfc0 (op 0x10, rs 0) with CP0RDW = 0x0000FF01, A3W = 8, and reset asserted on the same edge → gpr[8] = 0 and retired = 0.
